serial_tx: RTL and testbench
============================

Name: serial_tx

Overview:
- Parallel-to-serial transmitter: accepts a WIDTH-bit word over a valid/ready handshake and drives it onto a single line.
- Frame: start bit (0), data bits LSB first, stop bit (1). Each bit is held for BIT_CYCLES clocks.
- Sits between parallel logic built from the team's gate primitives and a one-wire link.

Parameters:
- WIDTH, 8, data bits per frame (legal range 1..16).
- BIT_CYCLES, 4, clocks per serial bit (≥1).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- data_in  input  WIDTH  word to transmit.
- valid  input  1  data_in is valid.
- ready  output  1  block can accept a word this cycle.
- tx  output  1  serial line; idles high.
- busy  output  1  frame in progress.

Behaviour:
- Reset, asynchronous and active-high: state=IDLE, tx=1, ready=1, busy=0, shift register=0, bit counter=0, cycle counter=0. Reset asserted mid-frame aborts the frame at once and tx returns to 1 without waiting for a clock.
- Handshake: a transfer occurs on a rising edge where valid&ready=1. data_in is captured into the shift register on that edge.
  - ready=1 only in IDLE and is registered.
  - valid while ready=0 is ignored; data is not queued. The sender must hold valid until ready.
- FSM:
  - IDLE: tx=1. On transfer, go to START; busy=1 and ready=0 from the next cycle.
  - START: tx=0 for BIT_CYCLES clocks, then go to DATA.
  - DATA: tx=shift_reg[0] for BIT_CYCLES clocks per bit, then shift right. After WIDTH bits, go to PARITY if enabled, else STOP.
  - PARITY (optional): one bit period, see Optional Feature.
  - STOP: tx=1 for BIT_CYCLES clocks, then go to IDLE; ready=1 and busy=0 on the following cycle.
- Timing:
  - The first tx=0 appears in the cycle after the transfer edge.
  - Frame length = (WIDTH+2)*BIT_CYCLES clocks, plus BIT_CYCLES if parity is enabled.
  - Minimum spacing between transfer edges = frame length + 1 clock (the idle cycle in which ready is re-asserted).
- Counters:
  - The cycle counter counts 0..BIT_CYCLES-1 and wraps to 0 at each bit boundary.
  - The bit counter is sized $clog2(WIDTH+1) and must not overflow at WIDTH=16.
  - BIT_CYCLES=1 gives one bit per clock and must work.
- tx is driven from a register: no combinational glitches, no X after reset.
- data_in changing after the transfer edge has no effect on the frame in flight.

Optional Feature:
- Macro SERIAL_TX_PARITY_EN.
  - Defined: an even-parity bit (XOR of all WIDTH data bits) is inserted between the last data bit and the stop bit, held BIT_CYCLES clocks. Frame grows by BIT_CYCLES.
  - Undefined: the PARITY state does not exist and the frame goes DATA -> STOP.

Test Plan:
- Reset: rst=1 mid-simulation, mid-frame at WIDTH=8, BIT_CYCLES=4 -> tx=1, ready=1, busy=0 immediately, with no clock edge needed.
- Single frame: data_in=8'hA5, valid pulse while ready=1, BIT_CYCLES=4 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 clocks; ready returns after 40 clocks plus 1.
- Back-to-back: valid held high with 8'h00 then 8'hFF -> second frame starts exactly 1 idle cycle after the first stop bit ends; no frame is lost or duplicated.
- Ignored valid: assert valid with 8'h3C while busy -> current frame unchanged, 8'h3C never transmitted unless valid is still high when ready=1.
- BIT_CYCLES=1, WIDTH=16, data 16'h8001 -> 18-clock frame; tx bits: 0, 1, fourteen 0s, 1, stop 1.
- SERIAL_TX_PARITY_EN defined:
  - 8'h07 -> parity bit 1 before stop; frame 44 clocks at BIT_CYCLES=4.
  - 8'h03 -> parity bit 0.

Source files
------------

// File: rtl/serial_tx.sv
// serial_tx: valid/ready parallel-to-serial transmitter (start, LSB-first data, stop).
// Optional even-parity bit before the stop bit when SERIAL_TX_PARITY_EN is defined.
module serial_tx #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid,
    output logic             ready,
    output logic             tx,
    output logic             busy
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] CYC_ONE  = CW'(1);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4
    } state_t;
`endif

    // Even parity: XOR of all data bits.
    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    state_t           state_r;
    state_t           next_state_s;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] shift_s;
    logic [BW-1:0]    bit_cnt_r;
    logic [BW-1:0]    bit_cnt_s;
    logic [CW-1:0]    cyc_cnt_r;
    logic [CW-1:0]    cyc_cnt_s;
    logic             bit_end_s;
    logic             tx_s;
    logic             ready_s;
    logic             busy_s;
`ifdef SERIAL_TX_PARITY_EN
    logic             parity_r;
    logic             parity_s;
`endif

    assign bit_end_s = (cyc_cnt_r == CYC_LAST);

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            shift_r   <= '0;
            bit_cnt_r <= '0;
            cyc_cnt_r <= '0;
            tx        <= 1'b1;
            ready     <= 1'b1;
            busy      <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_r  <= 1'b0;
`endif
        end else begin
            state_r   <= next_state_s;
            shift_r   <= shift_s;
            bit_cnt_r <= bit_cnt_s;
            cyc_cnt_r <= cyc_cnt_s;
            tx        <= tx_s;
            ready     <= ready_s;
            busy      <= busy_s;
`ifdef SERIAL_TX_PARITY_EN
            parity_r  <= parity_s;
`endif
        end
    end

    // Next-state and datapath update.
    always_comb begin
        next_state_s = state_r;
        shift_s      = shift_r;
        bit_cnt_s    = bit_cnt_r;
        cyc_cnt_s    = cyc_cnt_r;
`ifdef SERIAL_TX_PARITY_EN
        parity_s     = parity_r;
`endif
        case (state_r)
            S_IDLE: begin
                cyc_cnt_s = '0;
                bit_cnt_s = '0;
                if (valid && ready) begin
                    next_state_s = S_START;
                    shift_s      = data_in;
`ifdef SERIAL_TX_PARITY_EN
                    parity_s     = even_parity(data_in);
`endif
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    next_state_s = S_DATA;
                    cyc_cnt_s    = '0;
                end else begin
                    cyc_cnt_s = cyc_cnt_r + CYC_ONE;
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    cyc_cnt_s = '0;
                    shift_s   = shift_r >> 1;
                    if (bit_cnt_r == BIT_LAST) begin
                        bit_cnt_s = '0;
`ifdef SERIAL_TX_PARITY_EN
                        next_state_s = S_PARITY;
`else
                        next_state_s = S_STOP;
`endif
                    end else begin
                        bit_cnt_s = bit_cnt_r + BIT_ONE;
                    end
                end else begin
                    cyc_cnt_s = cyc_cnt_r + CYC_ONE;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end_s) begin
                    next_state_s = S_STOP;
                    cyc_cnt_s    = '0;
                end else begin
                    cyc_cnt_s = cyc_cnt_r + CYC_ONE;
                end
            end
`endif
            S_STOP: begin
                if (bit_end_s) begin
                    next_state_s = S_IDLE;
                    cyc_cnt_s    = '0;
                end else begin
                    cyc_cnt_s = cyc_cnt_r + CYC_ONE;
                end
            end
            default: begin
                next_state_s = S_IDLE;
                cyc_cnt_s    = '0;
                bit_cnt_s    = '0;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state so tx is a clean flop.
    always_comb begin
        tx_s    = 1'b1;
        ready_s = (next_state_s == S_IDLE);
        busy_s  = (next_state_s != S_IDLE);
        case (next_state_s)
            S_IDLE:   tx_s = 1'b1;
            S_START:  tx_s = 1'b0;
            S_DATA:   tx_s = shift_s[0];
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: tx_s = parity_s;
`endif
            S_STOP:   tx_s = 1'b1;
            default:  tx_s = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: a WIDTH=8/BIT_CYCLES=4 instance and a WIDTH=16/BIT_CYCLES=1 instance.
// Frames expected by the drivers are queued; per-instance monitors pop and check tx bit by bit.
module tb_serial_tx;

`ifdef SERIAL_TX_PARITY_EN
    localparam int FRAME8  = 44;
    localparam int FRAME16 = 19;
`else
    localparam int FRAME8  = 40;
    localparam int FRAME16 = 18;
`endif

    typedef struct {
        logic [18:0] bits;
        int          nbits;
        int          start;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  data8 = 8'h00;
    logic        valid8 = 1'b0;
    logic        ready8, tx8, busy8;
    logic [15:0] data16 = 16'h0000;
    logic        valid16 = 1'b0;
    logic        ready16, tx16, busy16;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic mon8_en = 1'b1;
    exp_t q8[$];
    exp_t q16[$];

    serial_tx #(.WIDTH(8), .BIT_CYCLES(4)) dut8 (
        .clk(clk), .rst(rst), .data_in(data8), .valid(valid8),
        .ready(ready8), .tx(tx8), .busy(busy8)
    );

    serial_tx #(.WIDTH(16), .BIT_CYCLES(1)) dut16 (
        .clk(clk), .rst(rst), .data_in(data16), .valid(valid16),
        .ready(ready16), .tx(tx16), .busy(busy16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic cur_tx(input int sel);
        return (sel != 0) ? tx16 : tx8;
    endfunction

    function automatic logic cur_ready(input int sel);
        return (sel != 0) ? ready16 : ready8;
    endfunction

    function automatic logic cur_busy(input int sel);
        return (sel != 0) ? busy16 : busy8;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the first cycle of the frame, valid still high.
    task automatic drive(input int sel, input logic [15:0] d, input logic par,
                         input logic push, output int t);
        exp_t e;
        int   n;
        if (sel != 0) begin
            data16 = d; valid16 = 1'b1;
        end else begin
            data8 = d[7:0]; valid8 = 1'b1;
        end
        n = 0;
        while (cur_ready(sel) !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL drive timeout: ready=%b, required 1", cur_ready(sel));
            t = -1;
        end else begin
            @(posedge clk);
            #1;
            t = cyc;
            if (push) begin
                e.start = t;
                if (sel != 0) begin
`ifdef SERIAL_TX_PARITY_EN
                    e.bits = {1'b1, par, d, 1'b0}; e.nbits = 19;
`else
                    e.bits = 19'({1'b1, d, 1'b0}); e.nbits = 18;
`endif
                    q16.push_back(e);
                end else begin
`ifdef SERIAL_TX_PARITY_EN
                    e.bits = 19'({1'b1, par, d[7:0], 1'b0}); e.nbits = 11;
`else
                    e.bits = 19'({1'b1, d[7:0], 1'b0}); e.nbits = 10;
`endif
                    q8.push_back(e);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_idle(input int sel);
        int n;
        n = 0;
        while (cur_ready(sel) !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL idle timeout: ready=%b, required 1", cur_ready(sel));
        end
    endtask

    // Monitor: on each falling tx, pop an expected frame and check every sampled cycle of every bit.
    task automatic run_mon(input int sel);
        exp_t e;
        int   bc;
        int   n;
        logic bad;
        bc = (sel != 0) ? 1 : 4;
        forever begin
            @(negedge clk);
            if ((sel != 0 || mon8_en) && rst == 1'b0 && cur_tx(sel) === 1'b0) begin
                if ((sel != 0) ? (q16.size() == 0) : (q8.size() == 0)) begin
                    checks++; errors++;
                    $display("FAIL unexpected frame on dut%0d at cycle %0d: got start bit, required idle",
                             (sel != 0) ? 16 : 8, cyc);
                    n = 0;
                    while (cur_busy(sel) === 1'b1 && n < 100) begin
                        @(negedge clk);
                        n++;
                    end
                end else begin
                    e = (sel != 0) ? q16.pop_front() : q8.pop_front();
                    chkn($sformatf("start cycle dut%0d", (sel != 0) ? 16 : 8), cyc, e.start);
                    for (int i = 0; i < e.nbits; i++) begin
                        bad = 1'b0;
                        for (int c = 0; c < bc; c++) begin
                            if (i != 0 || c != 0) @(negedge clk);
                            if (cur_tx(sel) !== e.bits[i]) bad = 1'b1;
                        end
                        checks++;
                        if (bad) begin
                            errors++;
                            $display("FAIL tx bit %0d dut%0d: got %b, required %b held %0d cycles",
                                     i, (sel != 0) ? 16 : 8, cur_tx(sel), e.bits[i], bc);
                        end
                    end
                end
            end
        end
    endtask

    initial run_mon(0);
    initial run_mon(1);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, ta, tb;
        #1 rst = 1'b1;
        #1;
        chk1("reset tx", tx8, 1'b1);
        chk1("reset ready", ready8, 1'b1);
        chk1("reset busy", busy8, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single frame 8'hA5 with ready timing
        drive(0, 16'h00A5, 1'b0, 1'b1, t0);
        valid8 = 1'b0;
        chk1("ready after transfer", ready8, 1'b0);
        chk1("busy after transfer", busy8, 1'b1);
        wait_cyc(t0 + FRAME8 - 1);
        chk1("ready in last stop cycle", ready8, 1'b0);
        @(negedge clk);
        chk1("ready after frame", ready8, 1'b1);
        chk1("busy after frame", busy8, 1'b0);
        chk1("tx idle after frame", tx8, 1'b1);

        // Back-to-back with valid held
        drive(0, 16'h0000, 1'b0, 1'b1, ta);
        drive(0, 16'h00FF, 1'b0, 1'b1, tb);
        valid8 = 1'b0;
        chkn("back-to-back spacing", tb - ta, FRAME8 + 1);
        wait_idle(0);

        // Valid while busy is ignored; data_in changes mid-frame have no effect
        drive(0, 16'h00C3, 1'b0, 1'b1, t0);
        valid8 = 1'b0;
        repeat (5) @(negedge clk);
        data8 = 8'h3C; valid8 = 1'b1;
        repeat (20) @(negedge clk);
        valid8 = 1'b0;
        chk1("still busy during ignored valid", busy8, 1'b1);
        wait_idle(0);
        repeat (3) @(negedge clk);

        // WIDTH=16, BIT_CYCLES=1
        drive(1, 16'h8001, 1'b0, 1'b1, t0);
        valid16 = 1'b0;
        wait_cyc(t0 + FRAME16 - 1);
        chk1("dut16 ready in last stop cycle", ready16, 1'b0);
        @(negedge clk);
        chk1("dut16 ready after frame", ready16, 1'b1);

`ifdef SERIAL_TX_PARITY_EN
        drive(0, 16'h0007, 1'b1, 1'b1, t0);
        valid8 = 1'b0;
        wait_cyc(t0 + 43);
        chk1("parity frame ready at 43", ready8, 1'b0);
        @(negedge clk);
        chk1("parity frame ready at 44", ready8, 1'b1);
        drive(0, 16'h0003, 1'b0, 1'b1, t0);
        valid8 = 1'b0;
        wait_idle(0);
`endif

        // Asynchronous reset mid-frame
        repeat (3) @(negedge clk);
        mon8_en = 1'b0;
        drive(0, 16'h00A5, 1'b0, 1'b0, t0);
        valid8 = 1'b0;
        repeat (9) @(negedge clk);
        chk1("tx before reset (data bit 1)", tx8, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk1("async reset tx", tx8, 1'b1);
        chk1("async reset ready", ready8, 1'b1);
        chk1("async reset busy", busy8, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mon8_en = 1'b1;
        drive(0, 16'h005A, 1'b0, 1'b1, t0);
        valid8 = 1'b0;
        wait_idle(0);
        repeat (5) @(negedge clk);

        chkn("dut8 frames outstanding", q8.size(), 0);
        chkn("dut16 frames outstanding", q16.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
